nios2_qsys_mult_seq_cell: RTL and testbench

- Parametrised multi-cycle successor to the CPU's single-cycle 16x16 partial-product multiply cell.
- Computes the full 2*WIDTH-bit product and returns the low or high word, covering mul, mulxuu, mulxsu and mulxss.
- Uses one SLICE-wide partial product per cycle, with a valid/ready handshake on each side.
- Sits between the ALU issue stage and writeback, and stalls the pipeline while busy.

---
 rtl/nios2_qsys_mult_seq_cell.sv | 121 ++++++++++++
 tb/tb_nios2_qsys_mult_seq_cell.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/nios2_qsys_mult_seq_cell.sv
// Sequential WIDTHxWIDTH multiplier: one SLICE-wide partial product per CALC cycle, returns low/high word (mul, mulxuu, mulxsu, mulxss).
// Optional early-out when the remaining src2 slices are zero: define NIOS2_MULT_SEQ_EARLY_OUT_EN.
module nios2_qsys_mult_seq_cell #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mul_src1,
  input  logic [WIDTH-1:0] mul_src2,
  input  logic [1:0]       mul_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mul_result
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_mode;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic [W2-1:0]    r_acc;
  logic [KW-1:0]    r_k;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  int               w_k_int;
  logic [SLICE-1:0] w_slice;
  logic [W2-1:0]    w_pp;
  logic [W2-1:0]    w_p;
  logic             w_last;

  assign w_sa    = mul_mode[1] & mul_src1[WIDTH-1];
  assign w_sb    = (mul_mode == 2'b11) & mul_src2[WIDTH-1];
  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign w_mag_a = w_sa ? -mul_src1 : mul_src1;
  assign w_mag_b = w_sb ? -mul_src2 : mul_src2;

  assign w_k_int = int'(r_k);
  assign w_slice = SLICE'(r_mag_b >> (w_k_int * SLICE));
  assign w_pp    = (W2'(r_mag_a) * W2'(w_slice)) << (w_k_int * SLICE);
  assign w_p     = (r_sa ^ r_sb) ? -r_acc : r_acc;

`ifdef NIOS2_MULT_SEQ_EARLY_OUT_EN
  logic [WIDTH-1:0] w_rest;
  assign w_rest = r_mag_b >> ((w_k_int + 1) * SLICE);
  assign w_last = (r_k == KW'(N - 1)) || (w_rest == '0);
`else
  assign w_last = (r_k == KW'(N - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_mode      <= 2'b00;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_acc       <= '0;
      r_k         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mode     <= mul_mode;
            r_sa       <= w_sa;
            r_sb       <= w_sb;
            r_mag_a    <= w_mag_a;
            r_mag_b    <= w_mag_b;
            r_acc      <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_acc <= r_acc + w_pp;
          r_k   <= r_k + KW'(1);
          if (w_last) r_state <= FIN;
        end
        FIN: begin
          r_result    <= (r_mode == 2'b00) ? w_p[WIDTH-1:0] : w_p[W2-1:WIDTH];
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          // in_ready rises only after this edge, so no accept coincides with the handshake.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign mul_result = r_result;

endmodule

// File: tb/tb_nios2_qsys_mult_seq_cell.sv
// Directed bench for nios2_qsys_mult_seq_cell: modes, corner operands, latency, backpressure, mid-operation reset.
module tb_nios2_qsys_mult_seq_cell;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mul_src1 = '0;
  logic [31:0] mul_src2 = '0;
  logic [1:0]  mul_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] mul_result;

  int tests = 0;
  int fails = 0;

  nios2_qsys_mult_seq_cell #(.WIDTH(32), .SLICE(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_mode(mul_mode),
    .out_valid(out_valid), .out_ready(out_ready), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  // Drives one operation; lat = rising edges from accept edge until out_valid is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        output logic [31:0] res, output int lat);
    int w;
    w = 0;
    lat = 0;
    res = '0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(negedge clk);
    mul_src1 = a; mul_src2 = b; mul_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL op_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
    res = mul_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    tests++;
    if (mul_result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h required 00000000", mul_result); end
  endtask

  task automatic test_modes();
    logic [31:0] exp_r [4];
    logic [31:0] r;
    int lat;
    exp_r[0] = 32'h0000_0001; exp_r[1] = 32'hFFFF_FFFE;
    exp_r[2] = 32'hFFFF_FFFF; exp_r[3] = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'(i), r, lat);
      tests++;
      if (r !== exp_r[i]) begin fails++; $display("FAIL modes_m%0d: got %h required %h", i, r, exp_r[i]); end
    end
  endtask

  task automatic test_min_neg();
    logic [31:0] r;
    int lat;
    run_op(32'h8000_0000, 32'h8000_0000, 2'b11, r, lat);
    tests++;
    if (r !== 32'h4000_0000) begin fails++; $display("FAIL minneg_ss: got %h required 40000000", r); end
    run_op(32'h8000_0000, 32'h8000_0000, 2'b00, r, lat);
    tests++;
    if (r !== 32'h0000_0000) begin fails++; $display("FAIL minneg_lo: got %h required 00000000", r); end
    run_op(32'h8000_0000, 32'h0000_0003, 2'b10, r, lat);
    tests++;
    if (r !== 32'hFFFF_FFFE) begin fails++; $display("FAIL minneg_su: got %h required fffffffe", r); end
  endtask

  task automatic test_latency();
    logic [31:0] r;
    int lat;
    int exp_lat;
    run_op(32'h0001_0000, 32'h0001_0000, 2'b01, r, lat);
    tests++;
    if (r !== 32'h0000_0001) begin fails++; $display("FAIL lat_uu_result: got %h required 00000001", r); end
    tests++;
    if (lat != 3) begin fails++; $display("FAIL lat_uu_cycles: got %0d required 3", lat); end
`ifdef NIOS2_MULT_SEQ_EARLY_OUT_EN
    exp_lat = 2;
`else
    exp_lat = 3;
`endif
    run_op(32'h0000_0002, 32'h0000_1234, 2'b00, r, lat);
    tests++;
    if (r !== 32'h0000_2468) begin fails++; $display("FAIL lat_small_result: got %h required 00002468", r); end
    tests++;
    if (lat != exp_lat) begin fails++; $display("FAIL lat_small_cycles: got %0d required %0d", lat, exp_lat); end
  endtask

  task automatic test_backpressure();
    int w;
    logic [31:0] r;
    int lat;
    @(negedge clk);
    mul_src1 = 32'd3; mul_src2 = 32'd7; mul_mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep in_valid high with other operands while busy; they must be ignored.
    mul_src1 = 32'd9; mul_src2 = 32'd9;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b0;
    tests++;
    if (mul_result !== 32'h15) begin fails++; $display("FAIL bp_result: got %h required 00000015", mul_result); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (mul_result !== 32'h15 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold_%0d: result=%h in_ready=%0b out_valid=%0b required 00000015/0/1",
                 i, mul_result, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    run_op(32'd2, 32'h11, 2'b00, r, lat);
    tests++;
    if (r !== 32'h22) begin fails++; $display("FAIL bp_next: got %h required 00000022", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int lat;
    @(negedge clk);
    mul_src1 = 32'hFFFF_FFFF; mul_src2 = 32'hFFFF_FFFF; mul_mode = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_result !== 32'h0) begin
      fails++;
      $display("FAIL midreset: in_ready=%0b out_valid=%0b result=%h required 1/0/00000000",
               in_ready, out_valid, mul_result);
    end
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_no_out: out_valid=%0b required 0", out_valid); end
    run_op(32'd3, 32'd5, 2'b00, r, lat);
    tests++;
    if (r !== 32'h0000_000F) begin fails++; $display("FAIL midreset_next: got %h required 0000000f", r); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_min_neg();
    test_latency();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
